cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 141 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source 2-entry result FIFOs (ALU, BRU, LSB) granted round-robin
// onto a registered CDB. Define CDB_ARBITER_STATS_EN to add the conflict_cnt output.
module cdb_arbiter #(
  parameter int unsigned Q_WIDTH = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               flush_in,
  input  logic               alu_valid,
  input  logic [Q_WIDTH-1:0] alu_rob_pos,
  input  logic [31:0]        alu_value,
  input  logic               bru_valid,
  input  logic [Q_WIDTH-1:0] bru_rob_pos,
  input  logic [31:0]        bru_value,
  input  logic [31:0]        bru_npc,
  input  logic               lsb_valid,
  input  logic [Q_WIDTH-1:0] lsb_rob_pos,
  input  logic [31:0]        lsb_value,
  output logic               alu_ready,
  output logic               bru_ready,
  output logic               lsb_ready,
  output logic               cdb_valid,
  output logic [Q_WIDTH-1:0] cdb_rob_pos,
  output logic [31:0]        cdb_value,
  output logic [31:0]        cdb_npc,
  output logic [1:0]         cdb_src
`ifdef CDB_ARBITER_STATS_EN
  ,
  output logic [31:0]        conflict_cnt
`endif
);

  localparam int unsigned EW = Q_WIDTH + 64;

  // Entry layout: {npc, value, tag}
  logic [EW-1:0]      in_entry [3];
  logic [EW-1:0]      mem      [3][2];
  logic [2:0]         in_valid, push, pop, nonempty, ready;
  logic [2:0][1:0]    cnt;
  logic [2:0]         rd_ptr, wr_ptr;
  logic [1:0]         rr_ptr;
  logic               active;
  logic               gnt_valid;
  logic [1:0]         gnt_src;
  logic [EW-1:0]      gnt_entry;

  assign active = rdy_in & ~flush_in;

  always_comb begin
    in_valid    = {lsb_valid, bru_valid, alu_valid};
    in_entry[0] = {32'h0, alu_value, alu_rob_pos};
    in_entry[1] = {bru_npc, bru_value, bru_rob_pos};
    in_entry[2] = {32'h0, lsb_value, lsb_rob_pos};
    for (int i = 0; i < 3; i++) begin
      nonempty[i] = (cnt[i] != 2'd0);
      // Registered count only: a full FIFO refuses even when it pops this edge.
      ready[i]    = rst_in & rdy_in & (cnt[i] < 2'd2);
      push[i]     = in_valid[i] & ready[i] & ~flush_in;
    end
  end

  assign alu_ready = ready[0];
  assign bru_ready = ready[1];
  assign lsb_ready = ready[2];

  always_comb begin
    int unsigned j;
    j         = 0;
    gnt_valid = 1'b0;
    gnt_src   = 2'd0;
    gnt_entry = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      j = (32'(rr_ptr) + k) % 3;
      if (!gnt_valid && nonempty[j]) begin
        gnt_valid = 1'b1;
        gnt_src   = 2'(j);
        gnt_entry = mem[j][rd_ptr[j]];
      end
    end
    pop = '0;
    if (gnt_valid && active) pop[gnt_src] = 1'b1;
  end

  always_ff @(posedge clk_in) begin
    for (int i = 0; i < 3; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_entry[i];
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt         <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      rr_ptr      <= 2'd0;
      cdb_valid   <= 1'b0;
      cdb_rob_pos <= '0;
      cdb_value   <= '0;
      cdb_npc     <= '0;
      cdb_src     <= 2'd0;
    end else if (rdy_in) begin
      if (flush_in) begin
        cnt       <= '0;
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        rr_ptr    <= 2'd0;
        cdb_valid <= 1'b0;
      end else begin
        for (int i = 0; i < 3; i++) begin
          cnt[i] <= cnt[i] + {1'b0, push[i]} - {1'b0, pop[i]};
          if (push[i]) wr_ptr[i] <= ~wr_ptr[i];
          if (pop[i])  rd_ptr[i] <= ~rd_ptr[i];
        end
        cdb_valid <= gnt_valid;
        if (gnt_valid) begin
          cdb_rob_pos <= gnt_entry[Q_WIDTH-1:0];
          cdb_value   <= gnt_entry[Q_WIDTH +: 32];
          cdb_npc     <= gnt_entry[Q_WIDTH+32 +: 32];
          cdb_src     <= gnt_src;
          rr_ptr      <= (gnt_src == 2'd2) ? 2'd0 : gnt_src + 2'd1;
        end
      end
    end
  end

`ifdef CDB_ARBITER_STATS_EN
  logic [1:0] n_busy;
  assign n_busy = {1'b0, nonempty[0]} + {1'b0, nonempty[1]} + {1'b0, nonempty[2]};

  // Flush does not clear the statistic; only reset does.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      conflict_cnt <= '0;
    end else if (active && gnt_valid && (n_busy >= 2'd2) && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed + short random bench for cdb_arbiter; a per-source queue scoreboard predicts every
// broadcast. Checks conflict_cnt too when CDB_ARBITER_STATS_EN is defined.
module tb_cdb_arbiter;

  logic        clk_in, rst_in, rdy_in, flush_in;
  logic        alu_valid, bru_valid, lsb_valid;
  logic [3:0]  alu_rob_pos, bru_rob_pos, lsb_rob_pos;
  logic [31:0] alu_value, bru_value, lsb_value, bru_npc;
  logic        alu_ready, bru_ready, lsb_ready;
  logic        cdb_valid;
  logic [3:0]  cdb_rob_pos;
  logic [31:0] cdb_value, cdb_npc;
  logic [1:0]  cdb_src;
`ifdef CDB_ARBITER_STATS_EN
  logic [31:0] conflict_cnt;
`endif

  cdb_arbiter #(.Q_WIDTH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .alu_valid(alu_valid), .alu_rob_pos(alu_rob_pos), .alu_value(alu_value),
    .bru_valid(bru_valid), .bru_rob_pos(bru_rob_pos), .bru_value(bru_value),
    .bru_npc(bru_npc),
    .lsb_valid(lsb_valid), .lsb_rob_pos(lsb_rob_pos), .lsb_value(lsb_value),
    .alu_ready(alu_ready), .bru_ready(bru_ready), .lsb_ready(lsb_ready),
    .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos), .cdb_value(cdb_value),
    .cdb_npc(cdb_npc), .cdb_src(cdb_src)
`ifdef CDB_ARBITER_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] value;
    logic [31:0] npc;
  } ent_t;

  ent_t        sq [3][$];
  int          m_rr;
  bit          m_valid;
  logic [3:0]  m_tag;
  logic [31:0] m_value, m_npc, m_conf;
  logic [1:0]  m_src;
  int          n_vec, n_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_ready(input int i);
    return rst_in && rdy_in && (sq[i].size() < 2);
  endfunction

  function automatic ent_t src_entry(input int i);
    ent_t e;
    case (i)
      0:       begin e.tag = alu_rob_pos; e.value = alu_value; e.npc = 32'h0;   end
      1:       begin e.tag = bru_rob_pos; e.value = bru_value; e.npc = bru_npc; end
      default: begin e.tag = lsb_rob_pos; e.value = lsb_value; e.npc = 32'h0;   end
    endcase
    return e;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) sq[i].delete();
    m_rr = 0; m_valid = 0; m_conf = 0;
  endfunction

  // Called just after a rising edge with the inputs that were sampled at that edge.
  function automatic void model_edge();
    int   sz [3];
    int   g, ne;
    bit   gv;
    ent_t e;
    bit   v [3];
    if (!rst_in || !rdy_in) return;
    if (flush_in) begin
      for (int i = 0; i < 3; i++) sq[i].delete();
      m_rr = 0; m_valid = 0;
      return;
    end
    v[0] = alu_valid; v[1] = bru_valid; v[2] = lsb_valid;
    ne = 0; gv = 0; g = 0;
    for (int i = 0; i < 3; i++) begin
      sz[i] = sq[i].size();
      if (sz[i] > 0) ne++;
    end
    for (int k = 0; k < 3; k++) begin
      if (!gv && sz[(m_rr + k) % 3] > 0) begin gv = 1; g = (m_rr + k) % 3; end
    end
    m_valid = gv;
    if (gv) begin
      e = sq[g].pop_front();
      m_tag = e.tag; m_value = e.value; m_npc = e.npc; m_src = 2'(g);
      m_rr = (g + 1) % 3;
      if (ne >= 2 && m_conf != 32'hFFFF_FFFF) m_conf++;
    end
    for (int i = 0; i < 3; i++) begin
      if (v[i] && sz[i] < 2) sq[i].push_back(src_entry(i));
    end
  endfunction

  task automatic check_cdb();
    check("cdb_valid", cdb_valid, m_valid);
    if (m_valid) begin
      check("cdb_rob_pos", cdb_rob_pos, m_tag);
      check("cdb_value", cdb_value, m_value);
      check("cdb_npc", cdb_npc, m_npc);
      check("cdb_src", cdb_src, m_src);
    end
`ifdef CDB_ARBITER_STATS_EN
    check("conflict_cnt", conflict_cnt, m_conf);
`endif
  endtask

  task automatic step();
    @(negedge clk_in);
    check("alu_ready", alu_ready, exp_ready(0));
    check("bru_ready", bru_ready, exp_ready(1));
    check("lsb_ready", lsb_ready, exp_ready(2));
    @(posedge clk_in);
    model_edge();
    #1;
    check_cdb();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Asserts reset asynchronously mid-cycle, checks cleared outputs, releases after an edge.
  task automatic do_reset();
    rst_in = 1'b0;
    #1;
    model_reset();
    check("rst_cdb_valid", cdb_valid, 1'b0);
    check("rst_cdb_rob_pos", cdb_rob_pos, 4'h0);
    check("rst_cdb_value", cdb_value, 32'h0);
    check("rst_cdb_npc", cdb_npc, 32'h0);
    check("rst_cdb_src", cdb_src, 2'd0);
    check("rst_readys", {alu_ready, bru_ready, lsb_ready}, 3'b000);
`ifdef CDB_ARBITER_STATS_EN
    check("rst_conflict_cnt", conflict_cnt, 32'h0);
`endif
    @(posedge clk_in);
    #2;
    rst_in = 1'b1;
  endtask

  task automatic drive(input logic [2:0] v, input logic [3:0] ta, input logic [3:0] tb,
                       input logic [3:0] tl);
    {lsb_valid, bru_valid, alu_valid} = v;
    alu_rob_pos = ta; alu_value = 32'hA000_0000 | 32'(ta);
    bru_rob_pos = tb; bru_value = 32'hB000_0000 | 32'(tb); bru_npc = 32'h4000 + 32'(tb) * 4;
    lsb_rob_pos = tl; lsb_value = 32'hC000_0000 | 32'(tl);
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0;
    drive(3'b000, 0, 0, 0);
    model_reset();
    #1 do_reset();

    // Single ALU result: visible only in the cycle after the second edge
    drive(3'b001, 4'd3, 0, 0); alu_value = 32'h11;
    step();
    drive(3'b000, 0, 0, 0);
    run(3);

    // Three simultaneous pushes from reset drain ALU, BRU, LSB; second round starts at ALU again
    do_reset();
    drive(3'b111, 4'd1, 4'd2, 4'd3); step();
    drive(3'b000, 0, 0, 0);          run(4);
    drive(3'b111, 4'd4, 4'd5, 4'd6); step();
    drive(3'b000, 0, 0, 0);          run(4);

    // ALU fills to two entries behind BRU/LSB contention, stalls with rdy_in low, drains in order
    do_reset();
    drive(3'b111, 4'd1, 4'd5, 4'd9);  step();
    drive(3'b111, 4'd2, 4'd6, 4'd10); step();
    drive(3'b001, 4'd3, 0, 0);        step();
    drive(3'b001, 4'd4, 0, 0);
    rdy_in = 1'b0; run(2);
    rdy_in = 1'b1; run(3);
    drive(3'b000, 0, 0, 0); run(6);

    // Flush with two buffered results and a same-cycle LSB push
    drive(3'b011, 4'd1, 4'd2, 0);  step();
    drive(3'b100, 0, 0, 4'd7); flush_in = 1'b1; step();
    flush_in = 1'b0;
    drive(3'b000, 0, 0, 0); run(4);

    // Reset mid-stream with two entries still buffered
    drive(3'b111, 4'd1, 4'd2, 4'd3); step();
    drive(3'b000, 0, 0, 0);          step();
    do_reset();
    run(4);

    // Three simultaneous pushes again (conflict statistic reaches 2 after draining)
    drive(3'b111, 4'd7, 4'd8, 4'd9); step();
    drive(3'b000, 0, 0, 0);          run(4);

    // Random traffic including stalls and rare flushes
    for (int n = 0; n < 80; n++) begin
      drive(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)));
      alu_value = $urandom; bru_value = $urandom; lsb_value = $urandom; bru_npc = $urandom;
      rdy_in   = ($urandom_range(0, 7) != 0);
      flush_in = ($urandom_range(0, 15) == 0);
      step();
    end
    rdy_in = 1'b1; flush_in = 1'b0;
    drive(3'b000, 0, 0, 0);
    run(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
